// File: rtl/tick_stopwatch.sv
// BCD mm:ss stopwatch advanced by one-cycle ticks from the upstream prescaler.
// Optional lap freeze of the digit outputs is built when TICK_STOPWATCH_LAP_EN is defined.
module tick_stopwatch #(
    parameter int MIN_TENS_MAX = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover,
    output logic       lap_active
);

    localparam logic [3:0] MT_MAX = 4'(MIN_TENS_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] l_so, l_st, l_mo, l_mt;
    logic [3:0] n_so, n_st, n_mo, n_mt;
    logic       count_en;
    logic       wrap;

    assign count_en = tick && (state == RUN) && !clear;

    // Per-digit BCD cascade; each digit only moves when all lower digits wrap.
    always_comb begin
        n_so = l_so;
        n_st = l_st;
        n_mo = l_mo;
        n_mt = l_mt;
        wrap = 1'b0;
        if (count_en) begin
            if (l_so != 4'd9) begin
                n_so = l_so + 4'd1;
            end else begin
                n_so = 4'd0;
                if (l_st != 4'd5) begin
                    n_st = l_st + 4'd1;
                end else begin
                    n_st = 4'd0;
                    if (l_mo != 4'd9) begin
                        n_mo = l_mo + 4'd1;
                    end else begin
                        n_mo = 4'd0;
                        if (l_mt != MT_MAX) begin
                            n_mt = l_mt + 4'd1;
                        end else begin
                            n_mt = 4'd0;
                            wrap = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            state    <= IDLE;
            running  <= 1'b0;
            rollover <= 1'b0;
            l_so     <= 4'd0;
            l_st     <= 4'd0;
            l_mo     <= 4'd0;
            l_mt     <= 4'd0;
        end else begin
            l_so     <= n_so;
            l_st     <= n_st;
            l_mo     <= n_mo;
            l_mt     <= n_mt;
            rollover <= wrap;
            if (start_stop) begin
                if (state == RUN) begin
                    state   <= PAUSE;
                    running <= 1'b0;
                end else begin
                    state   <= RUN;
                    running <= 1'b1;
                end
            end
        end
    end

`ifdef TICK_STOPWATCH_LAP_EN
    logic       frozen;
    logic       lap_hit;
    logic [3:0] d_so, d_st, d_mo, d_mt;

    assign lap_hit = lap && (state != IDLE);

    // The display registers double as the hold register while frozen.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            frozen <= 1'b0;
            d_so   <= 4'd0;
            d_st   <= 4'd0;
            d_mo   <= 4'd0;
            d_mt   <= 4'd0;
        end else begin
            if (lap_hit) begin
                frozen <= !frozen;
            end
            if (lap_hit && !frozen) begin
                d_so <= l_so;
                d_st <= l_st;
                d_mo <= l_mo;
                d_mt <= l_mt;
            end else if (!(frozen && !lap_hit)) begin
                d_so <= n_so;
                d_st <= n_st;
                d_mo <= n_mo;
                d_mt <= n_mt;
            end
        end
    end

    assign sec_ones   = d_so;
    assign sec_tens   = d_st;
    assign min_ones   = d_mo;
    assign min_tens   = d_mt;
    assign lap_active = frozen;
`else
    logic unused_lap;
    assign unused_lap = lap;

    assign sec_ones   = l_so;
    assign sec_tens   = l_st;
    assign min_ones   = l_mo;
    assign min_tens   = l_mt;
    assign lap_active = 1'b0;
`endif

endmodule

// File: tb/tb_tick_stopwatch.sv
// Scoreboard bench for tick_stopwatch: a seconds-count model predicts each cycle's outputs.
module tb_tick_stopwatch;

    localparam int MAXT  = 5;
    localparam int LIMIT = (MAXT + 1) * 600;
`ifdef TICK_STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       lap = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, rollover, lap_active;

    tick_stopwatch #(.MIN_TENS_MAX(MAXT)) dut (
        .clk(clk), .reset(reset), .tick(tick), .start_stop(start_stop),
        .clear(clear), .lap(lap), .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens), .running(running),
        .rollover(rollover), .lap_active(lap_active)
    );

    always #5 clk = ~clk;

    // Reference model: elapsed seconds as a plain integer plus a mode.
    int  m_secs = 0;
    int  m_mode = M_IDLE;
    bit  m_roll = 1'b0;
    bit  m_lap  = 1'b0;
    int  m_hold = 0;

    logic [18:0] exp_q[$];
    int compared   = 0;
    int mismatched = 0;

    function automatic logic [18:0] expected_vec();
        int d;
        d = m_lap ? m_hold : m_secs;
        return {4'(d / 600), 4'((d / 60) % 10), 4'((d % 60) / 10), 4'(d % 10),
                (m_mode == M_RUN), m_roll, m_lap};
    endfunction

    task automatic model_step(input logic r, c, s, t, l);
        int old_mode;
        int old_secs;
        if (!r || c) begin
            m_secs = 0;
            m_mode = M_IDLE;
            m_roll = 1'b0;
            m_lap  = 1'b0;
        end else begin
            old_mode = m_mode;
            old_secs = m_secs;
            m_roll   = 1'b0;
            if (old_mode == M_RUN && t) begin
                m_secs = m_secs + 1;
                if (m_secs == LIMIT) begin
                    m_secs = 0;
                    m_roll = 1'b1;
                end
            end
            if (s) m_mode = (old_mode == M_RUN) ? M_PAUSE : M_RUN;
            if (LAP_EN && l && old_mode != M_IDLE) begin
                if (!m_lap) m_hold = old_secs;
                m_lap = !m_lap;
            end
        end
    endtask

    task automatic drive(input logic r, c, s, t, l);
        @(negedge clk);
        reset = r; clear = c; start_stop = s; tick = t; lap = l;
        @(posedge clk);
        model_step(r, c, s, t, l);
        exp_q.push_back(expected_vec());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 1, 0);
    endtask

    task automatic restart();
        drive(1, 1, 0, 0, 0);
        drive(1, 0, 1, 0, 0);
    endtask

    // Monitor: outputs are presented every cycle, so each edge pops one expectation.
    always @(posedge clk) begin
        logic [18:0] got;
        logic [18:0] exp;
        #1;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            got = {min_tens, min_ones, sec_tens, sec_ones, running, rollover, lap_active};
            compared++;
            if (got !== exp) begin
                mismatched++;
                $display("FAIL outputs @%0t: got %h%h:%h%h run=%b roll=%b lap=%b, expected %h%h:%h%h run=%b roll=%b lap=%b",
                         $time, got[18:15], got[14:11], got[10:7], got[6:3], got[2], got[1], got[0],
                         exp[18:15], exp[14:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
            end
        end
    end

    initial begin
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 1, 1);
        idle(2);

        // 75 seconds from idle
        drive(1, 0, 1, 0, 0);
        ticks(75);
        idle(2);

        // 00:59 -> 01:00
        restart();
        ticks(59);
        idle(1);
        ticks(1);
        idle(1);

        // 59:59 -> 00:00 with rollover
        restart();
        ticks(LIMIT - 1);
        idle(1);
        ticks(1);
        idle(3);

        // tick with start_stop in RUN, then ticks while paused
        restart();
        ticks(10);
        drive(1, 0, 1, 1, 0);
        ticks(5);
        // tick with start_stop in PAUSE is not counted
        drive(1, 0, 1, 1, 0);
        ticks(2);

        // clear with tick at 03:27, then reset at 03:27
        restart();
        ticks(207);
        drive(1, 1, 0, 1, 0);
        idle(1);
        drive(1, 0, 1, 0, 0);
        ticks(207);
        drive(0, 0, 0, 1, 0);
        idle(2);

        // lap freeze around ten ticks, and lap in IDLE
        drive(1, 0, 0, 0, 1);
        restart();
        ticks(20);
        drive(1, 0, 0, 0, 1);
        ticks(10);
        drive(1, 0, 0, 0, 1);
        idle(2);
        drive(1, 0, 0, 1, 1);
        ticks(4);
        drive(1, 1, 0, 0, 0);
        idle(1);

        // randomized control mix
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 149) == 0),
                  ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 24) == 0));
        end
        idle(2);

        @(negedge clk);
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/tick_stopwatch.md
# tick_stopwatch

BCD minutes:seconds stopwatch driven by a one-cycle `tick` pulse from the upstream programmable prescaler/counter stage. That stage is configured for one pulse per second. The block sits directly downstream of the prescaler and drives the display/decoder stage with four BCD digits. Control is by single-cycle pulses: start/stop, clear and lap.

## Interface
Parameters:
- `MIN_TENS_MAX`, default 5: highest minutes-tens digit. Count wraps after `MIN_TENS_MAX`9:59. Legal range 0–9.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-low.
- `tick`  in  1  one-cycle count-enable pulse from the upstream prescaler.
- `start_stop`  in  1  one-cycle pulse that toggles between running and paused.
- `clear`  in  1  one-cycle pulse that zeroes the count and returns to IDLE.
- `lap`  in  1  one-cycle pulse that toggles display freeze (only with `TICK_STOPWATCH_LAP_EN`).
- `sec_ones`  out  4  BCD seconds units, 0–9.
- `sec_tens`  out  4  BCD seconds tens, 0–5.
- `min_ones`  out  4  BCD minutes units, 0–9.
- `min_tens`  out  4  BCD minutes tens, 0–`MIN_TENS_MAX`.
- `running`  out  1  high in RUN.
- `rollover`  out  1  one-cycle pulse on wrap to 00:00.
- `lap_active`  out  1  high while the display is frozen.

## Operation
- FSM states: IDLE, RUN, PAUSE.
  - IDLE –start_stop→ RUN.
  - RUN –start_stop→ PAUSE.
  - PAUSE –start_stop→ RUN.
  - Any state –clear→ IDLE.
- Input priority in one cycle: `reset` > `clear` > `start_stop`/`tick`.
- The internal counter advances only when `tick`=1 and the current (registered) state is RUN.
  - `tick` together with `start_stop` while in RUN: the tick is counted and the state becomes PAUSE.
  - `tick` together with `start_stop` while in IDLE or PAUSE: the tick is not counted and the state becomes RUN.
- Digit cascade:
  - `sec_ones` 9→0 carries into `sec_tens`.
  - `sec_tens` 5→0 carries into `min_ones`.
  - `min_ones` 9→0 carries into `min_tens`.
  - `min_tens`=`MIN_TENS_MAX` with all lower digits at maximum → all digits 0. `rollover`=1 for one cycle and the state stays RUN.
- All arithmetic is per-digit, 4-bit BCD. Non-BCD values are never produced.
- `clear` zeroes the counter and digit outputs, drops to IDLE, and releases any lap freeze. A tick in the same cycle is ignored.
- `running` = (state == RUN).

## Timing
- Every output is registered. Reset values: all digits 0, `running`=0, `rollover`=0, `lap_active`=0, state IDLE.
- Latency:
  - Digit outputs change on the clock edge that samples `tick`, so the new value is visible in the next cycle.
  - `running` updates on the edge that samples `start_stop`.
  - `rollover` is asserted in the cycle after the tick that wraps the count, coincident with the 00:00 digits.
- A reset asserted mid-count takes effect at the next `clk` edge and forces the reset values above. There is no asynchronous path.
- Back-to-back ticks (on every cycle) must count correctly. The block must not assume any minimum tick spacing.

## Configuration
- `TICK_STOPWATCH_LAP_EN` defined:
  - A `lap` pulse in RUN or PAUSE toggles `lap_active`.
  - On entry to freeze, the current count is copied into a hold register and the digit outputs show the held value.
  - Internal counting continues while frozen.
  - On leaving freeze, the digit outputs show the live count in the next cycle.
  - `lap` is ignored in IDLE.
  - `clear` releases the freeze.
- Not defined: `lap` is ignored, `lap_active` is tied 0, digit outputs always show the live count, and no hold register exists.

## Test plan
- Reset, then `start_stop`, then 75 ticks → digits 01:15, `running`=1, `rollover` never asserted.
- Count to 00:59, apply one tick → 01:00 on the following cycle.
- `MIN_TENS_MAX`=5, count to 59:59, apply one tick → 00:00, `rollover` high for exactly one cycle, `running` stays 1.
- In RUN at 00:10, apply `tick` and `start_stop` in the same cycle → 00:11 and PAUSE. Apply 5 more ticks → still 00:11.
- At 03:27 in RUN, apply `clear` together with `tick` → 00:00, IDLE, `running`=0. Separately, drive `reset`=0 at 03:27 → all outputs at reset values after one edge.
- With `TICK_STOPWATCH_LAP_EN`: at 00:20 apply `lap`, then 10 ticks → display holds 00:20 with `lap_active`=1. Apply `lap` again → display shows 00:30 and `lap_active`=0. Without the macro, the same stimulus shows 00:30 throughout and `lap_active`=0.
